mano_timing_ctrl: RTL and testbench

MANO_TIMING_CTRL -- requirements
Module: mano_timing_ctrl

---
 rtl/mano_pkg.sv | 24 ++
 rtl/mano_dec3to8.sv | 31 +++
 rtl/mano_timing_ctrl.sv | 113 +++++++++++
 tb/tb_mano_timing_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// ---------------------------------------------------------------------------
// mano_pkg
// Shared constants and types for the Mano basic-computer control slice.
//   T_W        : number of timing signals T0..T5
//   D_W        : number of opcode decode lines D0..D7
//   SC_W       : sequence counter width
//   OPC_REG_IO : opcode of the register-reference / IO instruction group
//   HLT_BIT    : IR bit that selects HLT within the register-reference group
// ---------------------------------------------------------------------------
package mano_pkg;

   localparam int         T_W        = 6;
   localparam int         D_W        = 8;
   localparam int         SC_W       = 3;
   localparam logic [2:0] OPC_REG_IO = 3'b111;
   localparam int         HLT_BIT    = 0;

   // Run flag S, kept as a two-state machine.
   typedef enum logic {
      ST_HALT = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

endpackage : mano_pkg

// File: rtl/mano_dec3to8.sv
// ---------------------------------------------------------------------------
// mano_dec3to8
// One-hot decoder with enable: dec[k] = en && (sel == k).
// Defaults to a full 3-to-8 decoder; OUT_W may be reduced when only the low
// outputs are consumed, so no unused decode lines are generated.
// Ports:
//   sel : binary select, IN_W bits
//   en  : enable; all outputs are 0 when low
//   dec : one-hot result, OUT_W bits
// ---------------------------------------------------------------------------
module mano_dec3to8 #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 8
) (
   input  logic [IN_W-1:0]  sel,
   input  logic             en,
   output logic [OUT_W-1:0] dec
);

   // NOTE: the default assignment before the loop keeps every output driven
   // on every path, so no latch is inferred.
   always_comb begin
      dec = '0;
      for (int k = 0; k < OUT_W; k++) begin
         if (en && (sel == IN_W'(k))) begin
            dec[k] = 1'b1;
         end
      end
   end

endmodule : mano_dec3to8

// File: rtl/mano_timing_ctrl.sv
// ---------------------------------------------------------------------------
// mano_timing_ctrl
// Timing and control core of the Mano basic computer: sequence counter,
// run flag S, registered indirect bit I, opcode decode and HLT detection.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   ir      : instruction register (ir[15]=I, ir[14:12]=opcode, ir[0]=HLT)
//   start   : run request, honoured only while halted
//   sc_clr  : end-of-instruction request, clears the sequence counter
//   T       : one-hot timing signals T0..T(T_STEPS-1), zero while halted
//   D       : one-hot decode of ir[14:12], valid at all times
//   I       : indirect bit captured at the end of T2
//   running : run flag S
//   sc      : current sequence count (debug)
// ---------------------------------------------------------------------------
module mano_timing_ctrl #(
   parameter int T_STEPS = 6,
   parameter int SC_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        ir,
   input  logic               start,
   input  logic               sc_clr,
   output logic [T_STEPS-1:0] T,
   output logic [7:0]         D,
   output logic               I,
   output logic               running,
   output logic [SC_W-1:0]    sc
);

   import mano_pkg::*;

   if (T_STEPS > (2 ** SC_W)) begin : g_bad_width
      $error("mano_timing_ctrl: SC_W too small for T_STEPS");
   end

   localparam logic [SC_W-1:0] SC_LAST = SC_W'(T_STEPS - 1);

   run_state_t state;
   logic       halt;
   logic       unused_ir;

   assign running = (state == ST_RUN);

   // T is decoded from registered sc and the registered run flag only, so
   // start and sc_clr never reach T combinationally.
   mano_dec3to8 #(
      .IN_W  (SC_W),
      .OUT_W (T_STEPS)
   ) u_t_dec (
      .sel (sc),
      .en  (running),
      .dec (T)
   );

   mano_dec3to8 #(
      .IN_W  (3),
      .OUT_W (D_W)
   ) u_d_dec (
      .sel (ir[14:12]),
      .en  (1'b1),
      .dec (D)
   );

   // HLT: register-reference group (D7, direct) with the HLT bit, at T3.
   // T[3] already implies running.
   assign halt = T[3] & D[OPC_REG_IO] & ~I & ir[HLT_BIT];

   // Address/operand bits are handled elsewhere in the datapath.
   assign unused_ir = ^ir[11:1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_HALT;
         sc    <= '0;
         I     <= 1'b0;
      end else begin
         if (T[2]) begin
            I <= ir[15];
         end

         case (state)
            ST_HALT: begin
               // sc_clr is meaningless while halted; sc stays parked at 0.
               sc <= '0;
               if (start) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // start is ignored here, including in the halting cycle.
               if (halt) begin
                  state <= ST_HALT;
                  sc    <= '0;
               end else if (sc_clr || (sc == SC_LAST)) begin
                  sc <= '0;
               end else begin
                  sc <= sc + 1'b1;
               end
            end
            default: begin
               state <= ST_HALT;
               sc    <= '0;
            end
         endcase
      end
   end

endmodule : mano_timing_ctrl

// File: tb/tb_mano_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mano_timing_ctrl
// Directed, table-driven bench for mano_timing_ctrl. Each table row gives the
// inputs held during one clock cycle and the outputs expected just after the
// rising edge that ends that cycle.
// ---------------------------------------------------------------------------
module tb_mano_timing_ctrl;

   typedef struct {
      logic [15:0] ir;
      logic        start;
      logic        sc_clr;
      logic [5:0]  exp_t;
      logic [2:0]  exp_sc;
      logic        exp_run;
      logic        exp_i;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [15:0] ir;
   logic        start;
   logic        sc_clr;
   logic [5:0]  t_sig;
   logic [7:0]  d_sig;
   logic        i_sig;
   logic        running;
   logic [2:0]  sc;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   mano_timing_ctrl #(
      .T_STEPS (6),
      .SC_W    (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ir      (ir),
      .start   (start),
      .sc_clr  (sc_clr),
      .T       (t_sig),
      .D       (d_sig),
      .I       (i_sig),
      .running (running),
      .sc      (sc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [15:0] v_ir, input logic v_start,
                      input logic v_clr, input logic [5:0] v_t,
                      input logic [2:0] v_sc, input logic v_run,
                      input logic v_i);
      vec_t v;
      v.ir      = v_ir;
      v.start   = v_start;
      v.sc_clr  = v_clr;
      v.exp_t   = v_t;
      v.exp_sc  = v_sc;
      v.exp_run = v_run;
      v.exp_i   = v_i;
      vecs.push_back(v);
   endtask

   initial begin
      // ---------------- table ----------------
      // start pulse, full T0..T5 walk and wrap
      add(16'h0000, 1, 0, 6'b000001, 3'd0, 1, 0);
      add(16'h0000, 0, 0, 6'b000010, 3'd1, 1, 0);
      add(16'h0000, 0, 0, 6'b000100, 3'd2, 1, 0);
      add(16'h0000, 0, 0, 6'b001000, 3'd3, 1, 0);
      add(16'h0000, 0, 0, 6'b010000, 3'd4, 1, 0);
      add(16'h0000, 0, 0, 6'b100000, 3'd5, 1, 0);
      add(16'h0000, 0, 0, 6'b000001, 3'd0, 1, 0);
      // start while running is ignored
      add(16'h0000, 1, 0, 6'b000010, 3'd1, 1, 0);
      add(16'h0000, 0, 0, 6'b000100, 3'd2, 1, 0);
      add(16'h0000, 0, 0, 6'b001000, 3'd3, 1, 0);
      // sc_clr during T3
      add(16'h0000, 0, 1, 6'b000001, 3'd0, 1, 0);
      add(16'h0000, 0, 0, 6'b000010, 3'd1, 1, 0);
      add(16'h0000, 0, 0, 6'b000100, 3'd2, 1, 0);
      add(16'h0000, 0, 0, 6'b001000, 3'd3, 1, 0);
      add(16'h0000, 0, 0, 6'b010000, 3'd4, 1, 0);
      add(16'h0000, 0, 0, 6'b100000, 3'd5, 1, 0);
      // sc_clr during T5, then during T0
      add(16'h0000, 0, 1, 6'b000001, 3'd0, 1, 0);
      add(16'h0000, 0, 1, 6'b000001, 3'd0, 1, 0);
      add(16'h0000, 0, 0, 6'b000010, 3'd1, 1, 0);
      // HLT (7001) reaches T3; start in the halting cycle is ignored
      add(16'h7001, 0, 0, 6'b000100, 3'd2, 1, 0);
      add(16'h7001, 0, 0, 6'b001000, 3'd3, 1, 0);
      add(16'h7001, 1, 0, 6'b000000, 3'd0, 0, 0);
      add(16'h7001, 1, 0, 6'b000001, 3'd0, 1, 0);
      // F001 (I=1): I captured at end of T2, no halt at T3
      add(16'hF001, 0, 0, 6'b000010, 3'd1, 1, 0);
      add(16'hF001, 0, 0, 6'b000100, 3'd2, 1, 0);
      add(16'hF001, 0, 0, 6'b001000, 3'd3, 1, 1);
      add(16'hF001, 0, 0, 6'b010000, 3'd4, 1, 1);
      // ir[15] drops outside T2: I holds
      add(16'h0000, 0, 0, 6'b100000, 3'd5, 1, 1);
      add(16'h0000, 0, 0, 6'b000001, 3'd0, 1, 1);
      add(16'h7001, 0, 0, 6'b000010, 3'd1, 1, 1);
      add(16'h7001, 0, 0, 6'b000100, 3'd2, 1, 1);
      add(16'h7001, 0, 0, 6'b001000, 3'd3, 1, 0);
      // halt and sc_clr together at T3: halt wins
      add(16'h7001, 0, 1, 6'b000000, 3'd0, 0, 0);
      // sc_clr while halted does nothing
      add(16'h7001, 0, 1, 6'b000000, 3'd0, 0, 0);
      add(16'h0000, 0, 0, 6'b000000, 3'd0, 0, 0);

      // ---------------- reset state ----------------
      rst    = 1'b1;
      ir     = 16'h3000;
      start  = 1'b0;
      sc_clr = 1'b0;
      #2;
      check("rst_T", 32'(t_sig), 32'h0);
      check("rst_sc", 32'(sc), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_I", 32'(i_sig), 32'h0);
      check("rst_D_follows_ir", 32'(d_sig), 32'h08);
      start = 1'b1;
      tick();
      check("rst_start_blocked", 32'(running), 32'h0);
      start = 1'b0;
      tick();
      rst = 1'b0;

      // ---------------- table replay ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         ir     = vecs[i].ir;
         start  = vecs[i].start;
         sc_clr = vecs[i].sc_clr;
         tick();
         check($sformatf("row%0d_T", i), 32'(t_sig), 32'(vecs[i].exp_t));
         check($sformatf("row%0d_sc", i), 32'(sc), 32'(vecs[i].exp_sc));
         check($sformatf("row%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
         check($sformatf("row%0d_I", i), 32'(i_sig), 32'(vecs[i].exp_i));
      end
      start  = 1'b0;
      sc_clr = 1'b0;

      // ---------------- D sweep ----------------
      for (int k = 0; k < 8; k++) begin
         logic [2:0] opc;
         opc = 3'(k);
         ir  = {1'b0, opc, 12'h000};
         #1;
         check($sformatf("D_opc%0d", k), 32'(d_sig), 32'(8'h01 << k));
      end

      // ---------------- async reset mid-T4 ----------------
      ir    = 16'h8000;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ar_T0", 32'(t_sig), 32'h01);
      for (int k = 0; k < 4; k++) tick();
      check("ar_sc4", 32'(sc), 32'h4);
      check("ar_T4", 32'(t_sig), 32'h10);
      check("ar_I_loaded", 32'(i_sig), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_sc_now", 32'(sc), 32'h0);
      check("ar_T_now", 32'(t_sig), 32'h0);
      check("ar_running_now", 32'(running), 32'h0);
      check("ar_I_now", 32'(i_sig), 32'h0);
      tick();
      rst = 1'b0;
      sc_clr = 1'b1;
      tick();
      check("ar_clr_ignored_T", 32'(t_sig), 32'h0);
      check("ar_clr_ignored_run", 32'(running), 32'h0);
      sc_clr = 1'b0;
      tick();
      check("ar_idle_T", 32'(t_sig), 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ar_restart_T0", 32'(t_sig), 32'h01);
      check("ar_restart_sc", 32'(sc), 32'h0);
      check("ar_restart_run", 32'(running), 32'h1);
      tick();
      check("ar_restart_T1", 32'(t_sig), 32'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mano_timing_ctrl
